// File: rtl/ifmap_fifo_pkg.sv
// ifmap_fifo_pkg
// Shared defaults and helpers for the input-feature-map FIFO array.
//   NUM_CH_DEF / DATA_W_DEF / DEPTH_DEF / CNT_W_DEF : parameter defaults
//   lvl_width()  : width of an occupancy count that can hold 0..DEPTH
//   LVL_W_DEF    : lvl_width(DEPTH_DEF)
package ifmap_fifo_pkg;

    localparam int NUM_CH_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;
    localparam int CNT_W_DEF  = 16;

    // One extra bit so that a completely full FIFO (level == DEPTH) is representable.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LVL_W_DEF = lvl_width(DEPTH_DEF);

endpackage

// File: rtl/ifmap_fifo_array_if.sv
// ifmap_fifo_array_if
// Bundles the per-channel push/pop/clear requests and all per-channel
// status, data and sticky-flag outputs of the FIFO array.
//   master : producer/consumer side (drives clear, push, push_data, pop)
//   slave  : FIFO array side (drives status, pop_data, pop_valid, flags)
interface ifmap_fifo_array_if
    import ifmap_fifo_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LVL_W  = LVL_W_DEF
) ();

    logic [NUM_CH-1:0]             clear;
    logic [NUM_CH-1:0]             push;
    logic [NUM_CH-1:0][DATA_W-1:0] push_data;
    logic [NUM_CH-1:0]             pop;

    logic [NUM_CH-1:0]             full;
    logic [NUM_CH-1:0]             almost_full;
    logic [NUM_CH-1:0]             not_empty;
    logic [NUM_CH-1:0][LVL_W-1:0]  level;
    logic [NUM_CH-1:0][DATA_W-1:0] pop_data;
    logic [NUM_CH-1:0]             pop_valid;
    logic [NUM_CH-1:0]             ch_done;
    logic [NUM_CH-1:0]             ovf_err;
    logic [NUM_CH-1:0]             udf_err;

    modport master (
        output clear, push, push_data, pop,
        input  full, almost_full, not_empty, level,
        input  pop_data, pop_valid, ch_done, ovf_err, udf_err
    );

    modport slave (
        input  clear, push, push_data, pop,
        output full, almost_full, not_empty, level,
        output pop_data, pop_valid, ch_done, ovf_err, udf_err
    );

endinterface

// File: rtl/ifmap_fifo_ch.sv
// ifmap_fifo_ch
// One channel of the FIFO array: circular buffer with occupancy level,
// registered read data, saturating pop counter and sticky flags.
//   clk, rst_n      : clock, async active-low reset
//   clear           : synchronous flush, overrides push/pop
//   push, push_data : write request / data (dropped when full)
//   pop             : read request (dropped when empty)
//   cfg_target      : pop count at which ch_done sets (0 = never)
//   full, almost_full, not_empty, level : status from current level
//   pop_data, pop_valid : read data, strobe one cycle after accepted pop
//   ch_done, ovf_err, udf_err : sticky until clear/reset
module ifmap_fifo_ch
    import ifmap_fifo_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    parameter int  CNT_W  = CNT_W_DEF,
    parameter int  AF_LVL = DEPTH - 1,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = lvl_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic [CNT_W-1:0]  cfg_target,
    output logic              full,
    output logic              almost_full,
    output logic              not_empty,
    output logic [LVL_W-1:0]  level,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              ch_done,
    output logic              ovf_err,
    output logic              udf_err
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [CNT_W-1:0]  pop_cnt;
    logic              push_ok;
    logic              pop_ok;

    assign full        = (level_q == LVL_W'(DEPTH));
    assign almost_full = (level_q >= LVL_W'(AF_LVL));
    assign not_empty   = (level_q != '0);
    assign level       = level_q;

    // Acceptance uses the pre-edge level, so at full a simultaneous push is
    // refused even though the pop frees a slot (no pass-through).
    assign push_ok = push && !full;
    assign pop_ok  = pop && not_empty;

    // Storage is not reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            pop_cnt   <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            ch_done   <= 1'b0;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            pop_cnt   <= '0;
            pop_valid <= 1'b0;
            ch_done   <= 1'b0;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
        end else begin
            pop_valid <= pop_ok;

            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
                if (pop_cnt != '1) begin
                    pop_cnt <= pop_cnt + 1'b1;
                end
            end

            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase

            if (push && !push_ok) begin
                ovf_err <= 1'b1;
            end
            if (pop && !pop_ok) begin
                udf_err <= 1'b1;
            end

            // Registered off the stored count: sets the cycle after the
            // count reaches the target.
            if ((cfg_target != '0) && (pop_cnt == cfg_target)) begin
                ch_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifmap_fifo_array.sv
// ifmap_fifo_array
// NUM_CH independent FIFO channels sharing one clock, reset and pop target.
//   clk, rst_n  : clock, async active-low reset
//   cfg_target  : common pop-count target for ch_done
//   bus (slave) : per-channel clear/push/pop requests and all status,
//                 read data and sticky flag outputs
module ifmap_fifo_array
    import ifmap_fifo_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int AF_LVL = DEPTH - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   cfg_target,
    ifmap_fifo_array_if.slave  bus
);

    localparam int LVL_W = lvl_width(DEPTH);

    logic [NUM_CH-1:0]             full_w;
    logic [NUM_CH-1:0]             almost_full_w;
    logic [NUM_CH-1:0]             not_empty_w;
    logic [NUM_CH-1:0][LVL_W-1:0]  level_w;
    logic [NUM_CH-1:0][DATA_W-1:0] pop_data_w;
    logic [NUM_CH-1:0]             pop_valid_w;
    logic [NUM_CH-1:0]             ch_done_w;
    logic [NUM_CH-1:0]             ovf_err_w;
    logic [NUM_CH-1:0]             udf_err_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ifmap_fifo_ch #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W),
            .AF_LVL (AF_LVL)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear       (bus.clear[i]),
            .push        (bus.push[i]),
            .push_data   (bus.push_data[i]),
            .pop         (bus.pop[i]),
            .cfg_target  (cfg_target),
            .full        (full_w[i]),
            .almost_full (almost_full_w[i]),
            .not_empty   (not_empty_w[i]),
            .level       (level_w[i]),
            .pop_data    (pop_data_w[i]),
            .pop_valid   (pop_valid_w[i]),
            .ch_done     (ch_done_w[i]),
            .ovf_err     (ovf_err_w[i]),
            .udf_err     (udf_err_w[i])
        );
    end

    assign bus.full        = full_w;
    assign bus.almost_full = almost_full_w;
    assign bus.not_empty   = not_empty_w;
    assign bus.level       = level_w;
    assign bus.pop_data    = pop_data_w;
    assign bus.pop_valid   = pop_valid_w;
    assign bus.ch_done     = ch_done_w;
    assign bus.ovf_err     = ovf_err_w;
    assign bus.udf_err     = udf_err_w;

endmodule

// File: tb/tb_ifmap_fifo_array.sv
// tb_ifmap_fifo_array
// Self-checking bench: a directed vector table on channel 0, hand-written
// corner sequences and a randomized run, all compared every cycle against
// a queue-based reference model of every channel.
module tb_ifmap_fifo_array;
    import ifmap_fifo_pkg::*;

    localparam int NCH   = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int LW    = 4;
    localparam int AF    = DEPTH - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cfg_target;

    always #5 clk = ~clk;

    ifmap_fifo_array_if #(.NUM_CH(NCH), .DATA_W(DW), .LVL_W(LW)) bus ();

    ifmap_fifo_array #(
        .NUM_CH (NCH),
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW),
        .AF_LVL (AF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_target (cfg_target),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: each channel is just a queue plus a few counters.
    logic [DW-1:0] mq [NCH][$];
    logic [DW-1:0] m_pd   [NCH];
    bit            m_pv   [NCH];
    bit            m_done [NCH];
    bit            m_ovf  [NCH];
    bit            m_udf  [NCH];
    int            m_cnt  [NCH];

    typedef struct {
        logic        push;
        logic        pop;
        logic [31:0] data;
        int          lvl;
        logic        full;
        logic        pv;
        logic [31:0] pd;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vecs [18];

    function automatic void chk(string name, int ch, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d got %0h expected %0h at %0t", name, ch, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_pd[c]   = '0;
            m_pv[c]   = 1'b0;
            m_done[c] = 1'b0;
            m_ovf[c]  = 1'b0;
            m_udf[c]  = 1'b0;
            m_cnt[c]  = 0;
        end
    endfunction

    // Applies the inputs present at the last rising edge to the model.
    function automatic void model_step();
        for (int c = 0; c < NCH; c++) begin
            if (bus.clear[c]) begin
                mq[c].delete();
                m_pv[c]   = 1'b0;
                m_done[c] = 1'b0;
                m_ovf[c]  = 1'b0;
                m_udf[c]  = 1'b0;
                m_cnt[c]  = 0;
            end else begin
                bit was_full;
                bit was_ne;
                bit done_n;
                was_full = (mq[c].size() == DEPTH);
                was_ne   = (mq[c].size() != 0);
                done_n   = m_done[c] || ((cfg_target != 0) && (m_cnt[c] == int'(cfg_target)));
                m_pv[c]  = 1'b0;
                if (bus.pop[c]) begin
                    if (was_ne) begin
                        m_pd[c] = mq[c].pop_front();
                        m_pv[c] = 1'b1;
                        if (m_cnt[c] < 65535) m_cnt[c]++;
                    end else begin
                        m_udf[c] = 1'b1;
                    end
                end
                if (bus.push[c]) begin
                    if (!was_full) mq[c].push_back(bus.push_data[c]);
                    else           m_ovf[c] = 1'b1;
                end
                m_done[c] = done_n;
            end
        end
    endfunction

    function automatic void check_all();
        for (int c = 0; c < NCH; c++) begin
            int n;
            n = mq[c].size();
            chk("level",       c, 64'(bus.level[c]),       64'(n));
            chk("full",        c, 64'(bus.full[c]),        64'(n == DEPTH));
            chk("almost_full", c, 64'(bus.almost_full[c]), 64'(n >= AF));
            chk("not_empty",   c, 64'(bus.not_empty[c]),   64'(n != 0));
            chk("pop_valid",   c, 64'(bus.pop_valid[c]),   64'(m_pv[c]));
            chk("pop_data",    c, 64'(bus.pop_data[c]),    64'(m_pd[c]));
            chk("ch_done",     c, 64'(bus.ch_done[c]),     64'(m_done[c]));
            chk("ovf_err",     c, 64'(bus.ovf_err[c]),     64'(m_ovf[c]));
            chk("udf_err",     c, 64'(bus.udf_err[c]),     64'(m_udf[c]));
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else        model_step();
        check_all();
    endtask

    task automatic idle();
        bus.clear     = '0;
        bus.push      = '0;
        bus.pop       = '0;
        bus.push_data = '0;
    endtask

    task automatic clear_all();
        idle();
        bus.clear = '1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        cfg_target = '0;
        model_reset();

        // Reset state before any clock edge.
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table on channel 0: fill past full, then drain past empty.
        for (int i = 0; i < 9; i++) begin
            vecs[i].push = 1'b1;
            vecs[i].pop  = 1'b0;
            vecs[i].data = 32'hA0 + 32'(i);
            vecs[i].lvl  = (i < 8) ? i + 1 : 8;
            vecs[i].full = (i >= 7);
            vecs[i].pv   = 1'b0;
            vecs[i].pd   = 32'h0;
            vecs[i].ovf  = (i == 8);
            vecs[i].udf  = 1'b0;
        end
        for (int j = 0; j < 9; j++) begin
            vecs[9+j].push = 1'b0;
            vecs[9+j].pop  = 1'b1;
            vecs[9+j].data = 32'h0;
            vecs[9+j].lvl  = (j < 8) ? 7 - j : 0;
            vecs[9+j].full = 1'b0;
            vecs[9+j].pv   = (j < 8);
            vecs[9+j].pd   = 32'hA0 + 32'((j < 8) ? j : 7);
            vecs[9+j].ovf  = 1'b1;
            vecs[9+j].udf  = (j == 8);
        end
        for (int k = 0; k < 18; k++) begin
            idle();
            bus.push[0]      = vecs[k].push;
            bus.pop[0]       = vecs[k].pop;
            bus.push_data[0] = vecs[k].data;
            tick();
            chk("tbl_level", 0, 64'(bus.level[0]),     64'(vecs[k].lvl));
            chk("tbl_full",  0, 64'(bus.full[0]),      64'(vecs[k].full));
            chk("tbl_pv",    0, 64'(bus.pop_valid[0]), 64'(vecs[k].pv));
            chk("tbl_pd",    0, 64'(bus.pop_data[0]),  64'(vecs[k].pd));
            chk("tbl_ovf",   0, 64'(bus.ovf_err[0]),   64'(vecs[k].ovf));
            chk("tbl_udf",   0, 64'(bus.udf_err[0]),   64'(vecs[k].udf));
        end
        idle();

        // Steady push+pop at level 3: pointers wrap several times.
        clear_all();
        for (int i = 0; i < 3; i++) begin
            bus.push[0] = 1'b1;
            bus.push_data[0] = $urandom;
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            bus.push[0] = 1'b1;
            bus.pop[0]  = 1'b1;
            bus.push_data[0] = $urandom;
            tick();
        end
        idle();
        chk("steady_level", 0, 64'(bus.level[0]), 64'd3);

        // Done detection on ch7 with target 5; ch6 holds data but never pops.
        clear_all();
        cfg_target = 16'd5;
        for (int i = 0; i < 5; i++) begin
            bus.push[7] = 1'b1;
            bus.push[6] = 1'b1;
            bus.push_data[7] = 32'h700 + 32'(i);
            bus.push_data[6] = 32'h600 + 32'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            bus.pop[7] = 1'b1;
            tick();
        end
        idle();
        tick();
        chk("done_ch7", 7, 64'(bus.ch_done[7]), 64'd1);
        chk("done_ch6", 6, 64'(bus.ch_done[6]), 64'd0);
        repeat (3) tick();
        chk("done_sticky", 7, 64'(bus.ch_done[7]), 64'd1);

        // Clear with simultaneous push on ch3; ch2 keeps its contents.
        clear_all();
        cfg_target = '0;
        for (int i = 0; i < 4; i++) begin
            bus.push[3] = 1'b1;
            bus.push[2] = (i < 2);
            bus.push_data[3] = 32'h300 + 32'(i);
            bus.push_data[2] = 32'h200 + 32'(i);
            tick();
        end
        idle();
        bus.pop[3] = 1'b1;
        tick();
        bus.pop[3] = 1'b0;
        bus.push[3] = 1'b1;
        bus.pop[2]  = 1'b0;
        bus.clear[3] = 1'b1;
        bus.push_data[3] = 32'hDEAD;
        tick();
        idle();
        chk("clr_level3", 3, 64'(bus.level[3]),     64'd0);
        chk("clr_pv3",    3, 64'(bus.pop_valid[3]), 64'd0);
        chk("clr_level2", 2, 64'(bus.level[2]),     64'd2);
        bus.pop[3] = 1'b1;
        tick();
        idle();
        chk("clr_dropped", 3, 64'(bus.udf_err[3]), 64'd1);

        // Randomized traffic on all channels.
        clear_all();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) cfg_target = CW'($urandom_range(0, 6));
            for (int c = 0; c < NCH; c++) begin
                bus.clear[c]     = ($urandom_range(0, 63) == 0);
                bus.push[c]      = ($urandom_range(0, 99) < 55);
                bus.pop[c]       = ($urandom_range(0, 99) < 50);
                bus.push_data[c] = $urandom;
            end
            tick();
        end
        idle();

        // Reset mid-stream with every channel half full.
        clear_all();
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < NCH; c++) begin
                bus.push[c] = 1'b1;
                bus.push_data[c] = $urandom;
            end
            tick();
        end
        bus.pop = '1;
        tick();
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < NCH; c++) begin
            chk("rst_level",     c, 64'(bus.level[c]),     64'd0);
            chk("rst_full",      c, 64'(bus.full[c]),      64'd0);
            chk("rst_not_empty", c, 64'(bus.not_empty[c]), 64'd0);
            chk("rst_pv",        c, 64'(bus.pop_valid[c]), 64'd0);
            chk("rst_pd",        c, 64'(bus.pop_data[c]),  64'd0);
            chk("rst_flags",     c, 64'({bus.ch_done[c], bus.ovf_err[c], bus.udf_err[c]}), 64'd0);
        end
        model_reset();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        bus.pop[0] = 1'b1;
        tick();
        chk("post_rst_udf", 0, 64'(bus.udf_err[0]), 64'd1);
        idle();
        bus.push[0] = 1'b1;
        bus.push_data[0] = 32'h5A5A5A5A;
        tick();
        idle();
        bus.pop[0] = 1'b1;
        tick();
        idle();
        chk("post_rst_pd", 0, 64'(bus.pop_data[0]), 64'h5A5A5A5A);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
